// File: rtl/reaction_pkg.sv
// Shared encodings, constants and helpers for the multi-player reaction timer.
// Imported by the tick generator and the core.
package reaction_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_GO   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [15:0] LFSR_SEED   = 16'hACE1;
    // Fibonacci taps 16,14,13,11 as a mask over a left-shifting register
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;
    localparam int          BLINK_TICKS = 250;

    function automatic int tick_cyc(input int sim_mode, input int clk_hz);
        return (sim_mode != 0) ? 2 : clk_hz / 1000;
    endfunction

    function automatic logic [2:0] lowest_idx(input logic [7:0] v);
        lowest_idx = 3'd0;
        for (int i = 7; i >= 0; i--)
            if (v[i]) lowest_idx = 3'(i);
    endfunction

endpackage

// File: rtl/reaction_core_multi_if.sv
// Game-side bus of the reaction core: player/control strobes in, round status out.
interface reaction_core_multi_if #(
    parameter int N_PLAYERS = 2,
    parameter int TIME_W    = 14
);
    logic                          iSTART;
    logic [N_PLAYERS-1:0]          iSTOP;
    logic                          iCLR_HS;
    logic [1:0]                    oSTATE;
    logic [TIME_W-1:0]             oTIMER;
    logic [N_PLAYERS*TIME_W-1:0]   oTIME;
    logic [N_PLAYERS-1:0]          oFOUL;
    logic [2:0]                    oWINNER;
    logic                          oWIN_VALID;
    logic [TIME_W-1:0]             oBEST;
    logic                          oNEW_BEST;
    logic [9:0]                    oLEDS;

    modport master (
        output iSTART, iSTOP, iCLR_HS,
        input  oSTATE, oTIMER, oTIME, oFOUL, oWINNER, oWIN_VALID, oBEST, oNEW_BEST, oLEDS
    );

    modport slave (
        input  iSTART, iSTOP, iCLR_HS,
        output oSTATE, oTIMER, oTIME, oFOUL, oWINNER, oWIN_VALID, oBEST, oNEW_BEST, oLEDS
    );
endinterface

// File: rtl/reaction_core_multi_tick.sv
// Millisecond strobe: one-cycle pulse every TICK_CYC clocks, restartable so the
// first pulse lands exactly TICK_CYC cycles after a clear.
module ms_tick_gen
    import reaction_pkg::*;
#(
    parameter int SIM_MODE = 0,
    parameter int CLK_HZ   = 50000000
) (
    input  logic iCLK,
    input  logic iRST_N,
    input  logic iCLR,
    output logic oTICK
);
    localparam int TICK_CYC = tick_cyc(SIM_MODE, CLK_HZ);
    localparam int CW       = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYC - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge iCLK) begin
        if (!iRST_N || iCLR)  cnt_q <= '0;
        else if (cnt_q == LAST) cnt_q <= '0;
        else                  cnt_q <= cnt_q + CW'(1);
    end

    assign oTICK = (cnt_q == LAST);
endmodule

// File: rtl/reaction_core_multi.sv
// N-player reaction timer: random pre-delay, false-start detection, per-player
// capture, winner selection and best-ever score.
module reaction_core_multi
    import reaction_pkg::*;
#(
    parameter int N_PLAYERS       = 2,
    parameter int TIME_W          = 14,
    parameter int MAX_TIME        = 9999,
    parameter int CLK_HZ          = 50000000,
    parameter int SIM_MODE        = 0,
    parameter int DELAY_MIN_MS    = 1000,
    parameter int DELAY_SPAN_MASK = 2047
) (
    input  logic                  iCLK,
    input  logic                  iRST_N,
    reaction_core_multi_if.slave  bus
);
    localparam logic [TIME_W-1:0] MAX_T = TIME_W'(MAX_TIME);

    state_t                           state_q;
    logic [TIME_W-1:0]                timer_q, best_q, win_time_q;
    logic [N_PLAYERS-1:0][TIME_W-1:0] times_q;
    logic [N_PLAYERS-1:0]             foul_q, fin_q;
    logic [2:0]                       winner_q;
    logic                             win_valid_q, new_best_q, first_q, blink_q;
    logic [7:0]                       blink_cnt_q;
    logic [15:0]                      lfsr_q, delay_q;

    logic                 tick, expire, tick_clr;
    logic [N_PLAYERS-1:0] new_stop, fin_nxt;
    logic [TIME_W-1:0]    timer_inc, timer_nxt;
    logic [9:0]           leds;

    assign new_stop  = bus.iSTOP & ~fin_q;
    assign fin_nxt   = fin_q | new_stop;
    assign expire    = tick && (delay_q <= 16'd1);
    assign timer_inc = (timer_q == MAX_T) ? timer_q : timer_q + TIME_W'(1);
    assign timer_nxt = tick ? timer_inc : timer_q;
    // Prescaler restarts when a round starts and when the delay runs out.
    assign tick_clr  = ((state_q == S_IDLE || state_q == S_DONE) && bus.iSTART)
                     || (state_q == S_WAIT && expire);

    ms_tick_gen #(.SIM_MODE(SIM_MODE), .CLK_HZ(CLK_HZ)) u_tick (
        .iCLK(iCLK), .iRST_N(iRST_N), .iCLR(tick_clr), .oTICK(tick)
    );

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            times_q     <= '0;
            foul_q      <= '0;
            fin_q       <= '0;
            winner_q    <= '0;
            win_valid_q <= 1'b0;
            win_time_q  <= '0;
            best_q      <= MAX_T;
            new_best_q  <= 1'b0;
            first_q     <= 1'b0;
            blink_q     <= 1'b0;
            blink_cnt_q <= '0;
            lfsr_q      <= LFSR_SEED;
            delay_q     <= '0;
        end else begin
            lfsr_q <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (state_q == S_DONE) begin
                        first_q <= 1'b0;
                        if (first_q && win_valid_q && win_time_q < best_q) begin
                            best_q     <= win_time_q;
                            new_best_q <= 1'b1;
                        end
                        if (new_best_q && tick) begin
                            if (blink_cnt_q == 8'(BLINK_TICKS - 1)) begin
                                blink_cnt_q <= '0;
                                blink_q     <= ~blink_q;
                            end else begin
                                blink_cnt_q <= blink_cnt_q + 8'd1;
                            end
                        end
                    end
                    if (bus.iCLR_HS) begin
                        best_q     <= MAX_T;
                        new_best_q <= 1'b0;
                    end
                    if (bus.iSTART) begin
                        state_q     <= S_WAIT;
                        delay_q     <= 16'(DELAY_MIN_MS) + (lfsr_q & 16'(DELAY_SPAN_MASK));
                        times_q     <= '0;
                        foul_q      <= '0;
                        fin_q       <= '0;
                        winner_q    <= '0;
                        win_valid_q <= 1'b0;
                        new_best_q  <= 1'b0;
                        timer_q     <= '0;
                        first_q     <= 1'b0;
                        blink_q     <= 1'b0;
                        blink_cnt_q <= '0;
                    end
                end
                S_WAIT: begin
                    if (tick && delay_q != 16'd0) delay_q <= delay_q - 16'd1;
                    for (int i = 0; i < N_PLAYERS; i++)
                        if (new_stop[i]) times_q[i] <= MAX_T;
                    foul_q <= foul_q | new_stop;
                    fin_q  <= fin_nxt;
                    // A foul in the expiry cycle counts before the GO decision.
                    if (&fin_nxt) begin
                        state_q <= S_DONE;
                        first_q <= 1'b1;
                    end else if (expire) begin
                        state_q <= S_GO;
                        timer_q <= '0;
                    end
                end
                S_GO: begin
                    timer_q <= timer_nxt;
                    fin_q   <= fin_nxt;
                    for (int i = 0; i < N_PLAYERS; i++)
                        if (new_stop[i]) times_q[i] <= timer_q;
                    if (!win_valid_q && |new_stop) begin
                        winner_q    <= lowest_idx(8'(new_stop));
                        win_valid_q <= 1'b1;
                        win_time_q  <= timer_q;
                    end
                    if (&fin_nxt) begin
                        state_q <= S_DONE;
                        first_q <= 1'b1;
                    end else if (timer_nxt == MAX_T) begin
                        state_q <= S_DONE;
                        first_q <= 1'b1;
                        fin_q   <= '1;
                        for (int i = 0; i < N_PLAYERS; i++)
                            if (!fin_nxt[i]) times_q[i] <= MAX_T;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // LED pattern is a pure decode of flops, so it tracks the state with no extra lag.
    always_comb begin
        leds = '0;
        case (state_q)
            S_GO:   leds = '1;
            S_DONE: begin
                if (win_valid_q) leds[winner_q] = 1'b1;
                leds[9:8] = {2{blink_q & new_best_q}};
            end
            default: leds = '0;
        endcase
    end

    assign bus.oSTATE     = state_q;
    assign bus.oTIMER     = timer_q;
    assign bus.oTIME      = times_q;
    assign bus.oFOUL      = foul_q;
    assign bus.oWINNER    = winner_q;
    assign bus.oWIN_VALID = win_valid_q;
    assign bus.oBEST      = best_q;
    assign bus.oNEW_BEST  = new_best_q;
    assign bus.oLEDS      = leds;
endmodule
